// File: rtl/cdrom_pkg.sv
// Shared types and entry-layout helpers for the CD-ROM command player.
package cdrom_pkg;

    localparam int unsigned OP_W = 2;

    // Script opcodes; reg/data fields are ignored for OpWaitIrq and OpEnd.
    typedef enum logic [1:0] {
        OpWrite   = 2'd0,
        OpRead    = 2'd1,
        OpWaitIrq = 2'd2,
        OpEnd     = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StWait = 2'd2,
        StFin  = 2'd3
    } player_state_e;

    // Width of the register-select field of a script entry.
    function automatic int unsigned reg_w(input int unsigned num_regs);
        return $clog2(num_regs);
    endfunction

    // Total script entry width: {op, reg, data}.
    function automatic int unsigned entry_w(input int unsigned num_regs,
                                            input int unsigned data_w);
        return OP_W + reg_w(num_regs) + data_w;
    endfunction

endpackage

// File: rtl/cdrom_cmd_player_if.sv
// Host-control, script-load and CD-ROM register-port signals of the command player.
interface cdrom_cmd_player_if #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned DEPTH    = 16
);
    import cdrom_pkg::*;

    localparam int unsigned PC_W    = $clog2(DEPTH);
    localparam int unsigned ENTRY_W = entry_w(NUM_REGS, DATA_W);

    // Host control and script load
    logic                         start;
    logic                         abort;
    logic                         loop;
    logic                         load_we;
    logic [PC_W-1:0]              load_addr;
    logic [ENTRY_W-1:0]           load_data;

    // CD-ROM register ports
    logic [NUM_REGS-1:0]          cd_we;
    logic [NUM_REGS-1:0]          cd_re;
    logic [DATA_W-1:0]            cd_wdata;
    logic [NUM_REGS*DATA_W-1:0]   cd_rdata;
    logic                         cd_irq;

    // Status
    logic [DATA_W-1:0]            rd_data;
    logic                         rd_valid;
    logic                         busy;
    logic                         done;
    logic                         err;
    logic [PC_W-1:0]              pc;

    // The player drives the register bus and reports status.
    modport master (
        input  start, abort, loop, load_we, load_addr, load_data, cd_rdata, cd_irq,
        output cd_we, cd_re, cd_wdata, rd_data, rd_valid, busy, done, err, pc
    );

    // Host / controller side.
    modport slave (
        output start, abort, loop, load_we, load_addr, load_data, cd_rdata, cd_irq,
        input  cd_we, cd_re, cd_wdata, rd_data, rd_valid, busy, done, err, pc
    );

endinterface

// File: rtl/cdrom_script_ram.sv
// Script storage: synchronous write, asynchronous read. Contents are not reset.
module cdrom_script_ram #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ENTRY_W = 12
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [ENTRY_W-1:0]       wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [ENTRY_W-1:0]       rdata
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/cdrom_cmd_player.sv
// Replays a loaded script of register writes, reads and IRQ waits against the CD-ROM
// controller register ports. All bus and status outputs come straight from flops.
module cdrom_cmd_player
    import cdrom_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    cdrom_cmd_player_if.master   bus
);

    localparam int unsigned PC_W    = $clog2(DEPTH);
    localparam int unsigned REG_W   = reg_w(NUM_REGS);
    localparam int unsigned ENTRY_W = entry_w(NUM_REGS, DATA_W);
    localparam int unsigned CNT_W   = $clog2(TIMEOUT);

    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    player_state_e       state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic [NUM_REGS-1:0] cd_we_q, cd_we_d;
    logic [NUM_REGS-1:0] cd_re_q, cd_re_d;
    logic [DATA_W-1:0]   cd_wdata_q, cd_wdata_d;
    logic                rd_pend_q, rd_pend_d;
    logic [REG_W-1:0]    rd_reg_q, rd_reg_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;

    logic [ENTRY_W-1:0]  entry;
    op_e                 ent_op;
    logic [REG_W-1:0]    ent_reg;
    logic [DATA_W-1:0]   ent_data;
    logic                advance;
    logic                finish;
    logic                ram_we;

    logic [DATA_W-1:0]   rdata_arr [NUM_REGS];

    // Script may only be rewritten while the player is idle.
    assign ram_we = bus.load_we && (state_q == StIdle);

    cdrom_script_ram #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_script_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (bus.load_addr),
        .wdata (bus.load_data),
        .raddr (pc_q),
        .rdata (entry)
    );

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_rdata
        assign rdata_arr[i] = bus.cd_rdata[i*DATA_W +: DATA_W];
    end

    assign ent_op   = op_e'(entry[ENTRY_W-1 -: OP_W]);
    assign ent_reg  = entry[DATA_W +: REG_W];
    assign ent_data = entry[DATA_W-1:0];

    // Next-state decode: issue the current entry, handle waits, end-of-script and abort.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        done_d     = 1'b0;
        cd_we_d    = '0;
        cd_re_d    = '0;
        cd_wdata_d = cd_wdata_q;
        rd_pend_d  = 1'b0;
        rd_reg_d   = rd_reg_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;

        // A read issued last cycle is captured regardless of state or abort.
        if (rd_pend_q) begin
            rd_data_d  = rdata_arr[rd_reg_q];
            rd_valid_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StRun;
                    pc_d    = '0;
                    err_d   = 1'b0;
                end
            end
            StRun: begin
                unique case (ent_op)
                    OpWrite: begin
                        cd_we_d    = NUM_REGS'(1) << ent_reg;
                        cd_wdata_d = ent_data;
                        advance    = 1'b1;
                    end
                    OpRead: begin
                        cd_re_d   = NUM_REGS'(1) << ent_reg;
                        rd_pend_d = 1'b1;
                        rd_reg_d  = ent_reg;
                        advance   = 1'b1;
                    end
                    OpWaitIrq: begin
                        state_d = StWait;
                        cnt_d   = '0;
                    end
                    OpEnd: begin
                        finish = 1'b1;
                    end
                endcase
            end
            StWait: begin
                if (bus.cd_irq) begin
                    state_d = StRun;
                    advance = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StFin: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
        endcase

        // The last slot behaves like an implicit END; pc never wraps on its own.
        if (advance) begin
            if (pc_q == PC_LAST) begin
                finish = 1'b1;
            end else begin
                pc_d = pc_q + PC_W'(1);
            end
        end

        if (finish) begin
            if (bus.loop) begin
                pc_d    = '0;
                state_d = StRun;
            end else begin
                state_d = StFin;
            end
        end

        // Abort beats everything, including a simultaneous start; err is left alone.
        if (bus.abort) begin
            state_d   = StIdle;
            cd_we_d   = '0;
            cd_re_d   = '0;
            rd_pend_d = 1'b0;
            done_d    = 1'b0;
            err_d     = err_q;
        end
    end

    // State and output registers; reset clears in-flight strobes asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            pc_q       <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            cd_we_q    <= '0;
            cd_re_q    <= '0;
            cd_wdata_q <= '0;
            rd_pend_q  <= 1'b0;
            rd_reg_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            done_q     <= done_d;
            cd_we_q    <= cd_we_d;
            cd_re_q    <= cd_re_d;
            cd_wdata_q <= cd_wdata_d;
            rd_pend_q  <= rd_pend_d;
            rd_reg_q   <= rd_reg_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.cd_we    = cd_we_q;
    assign bus.cd_re    = cd_re_q;
    assign bus.cd_wdata = cd_wdata_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.pc       = pc_q;

endmodule

// File: doc/cdrom_cmd_player.md
Name: cdrom_cmd_player

Overview:
- Parametrised command sequencer that replays a loadable script of register operations against the CD-ROM controller's register ports.
- Supports writes, reads and waits on the controller interrupt.
- Generalises the single hard-coded "write 0x06 to register 0" bring-up sequence into:
  - an N-entry script,
  - N register ports,
  - a configurable data width,
  - IRQ waits with timeout,
  - one-shot or looped playback.
- Sits between the board test top (keys/switches) and the cdrom block; also reused by simulation benches as a host-command driver.

Parameters:
- DATA_W, 8, register data width
- NUM_REGS, 4, number of CD-ROM register ports (addr0..addrN-1)
- DEPTH, 16, script entries
- TIMEOUT, 1024, max cycles in WAIT_IRQ before error

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  pulse; begin playback at entry 0
- abort  in  1  pulse; stop playback immediately
- loop  in  1  level; on END, restart at entry 0 instead of finishing
- load_we  in  1  script write strobe
- load_addr  in  clog2(DEPTH)  script entry index
- load_data  in  2+clog2(NUM_REGS)+DATA_W  entry {op, reg, data}
- cd_we  out  NUM_REGS  one-hot write strobe to register ports
- cd_re  out  NUM_REGS  one-hot read strobe
- cd_wdata  out  DATA_W  shared write data
- cd_rdata  in  NUM_REGS*DATA_W  register read data, 1-cycle latency after cd_re
- cd_irq  in  1  controller interrupt/response flag
- rd_data  out  DATA_W  last captured read value
- rd_valid  out  1  one-cycle pulse when rd_data updates
- busy  out  1  high while not IDLE
- done  out  1  one-cycle pulse on normal completion
- err  out  1  sticky timeout flag, cleared by next accepted start
- pc  out  clog2(DEPTH)  current entry index

Behaviour:
- Reset: state IDLE; pc=0; all strobes, rd_valid, done and err = 0; rd_data=0; cd_wdata=0. Script contents are not reset.
- Op codes: WRITE=0, READ=1, WAIT_IRQ=2, END=3. For WAIT_IRQ and END, the reg and data fields are ignored.
- States: IDLE, RUN, WAIT, FIN.
- Script load:
  - load_we writes the entry at the next edge, only in IDLE.
  - Ignored otherwise; no error.
- Start:
  - IDLE + start sampled at edge e: RUN at e, pc=0, err cleared.
  - Entry 0 is issued at edge e+1.
  - start while busy is ignored.
- RUN issues one entry per cycle. All outputs are registered.
- WRITE:
  - cd_we[reg]=1 and cd_wdata=data for exactly one cycle after the issuing edge; pc++.
  - Back-to-back writes give continuous strobes, one per cycle.
- READ:
  - cd_re[reg]=1 for one cycle.
  - cd_rdata[reg] is sampled at the following edge into rd_data, with rd_valid pulsed for one cycle.
  - The next entry issues at that same edge, so reads pipeline.
- WAIT_IRQ: RUN→WAIT with a cycle counter cleared.
  - cd_irq sampled high: pc++ and return to RUN at that edge.
  - Counter reaching TIMEOUT-1 without irq: set err, go to IDLE, no done.
  - cd_irq already high on entry: leave WAIT after one cycle.
- END, or the entry at pc=DEPTH-1 completing:
  - loop=1: pc=0, stay RUN.
  - loop=0: FIN, then done=1 for one cycle and IDLE.
- pc wraps to 0 only via loop. There is no implicit wrap past DEPTH-1.
- abort:
  - Any state → IDLE at the next edge; strobes deassert that cycle.
  - No done pulse; err unchanged.
  - A read in flight still completes its capture.
- start and abort in the same cycle: abort wins.
- Reset mid-operation: immediate return to the reset values. In-flight strobes drop asynchronously.

Decomposition:
- Package cdrom_pkg holds:
  - op_e enum (WRITE, READ, WAIT_IRQ, END),
  - player_state_e,
  - entry field width helper constants.
- One sub-module: cdrom_script_ram, the DEPTH x entry register array with a synchronous write port and an asynchronous read port indexed by pc.

Test Plan:
- Load [WRITE r0 0x06, END], pulse start → cd_we=4'b0001 with cd_wdata=0x06 for one cycle, exactly 2 cycles after start; done pulse 2 cycles later; busy low afterwards.
- Script [WRITE r1 0xA5, WRITE r3 0x3C, READ r2, END] with cd_rdata r2=0x5A → strobes on consecutive cycles; rd_data=0x5A, rd_valid pulsed once; done pulsed.
- [WAIT_IRQ, WRITE r0 0x01, END], irq raised 10 cycles after start → write issues the cycle after irq is sampled; err=0.
- [WAIT_IRQ, END] with TIMEOUT=16 and irq never raised → err=1 at cycle 16 of WAIT, no done, no strobes; next start clears err.
- loop=1, script [WRITE r0 0x11, END] → cd_we[0] every 2 cycles; abort → strobes stop the next cycle, busy=0, no done.
- load_we while busy → entry unchanged; start and abort together in IDLE → stays IDLE.
